vga_timing_core: RTL and testbench
==================================

Name: vga_timing_core

Overview:
- Parametrised successor of the fixed 640x480 timing generator.
- Timing set by parameters: active, front porch, sync and back porch, per axis.
- Adds per-axis sync polarity, fully registered outputs, a run enable, line/frame strobes, and a configurable output delay line so sync/de stay aligned with a downstream pixel pipeline (text overlay, sprite/menu renderers) of known latency.
- Sits between the pixel clock and the pixel generator / HDMI encoder.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- H_SYNC_POL, 0, 1 = h_sync active-high, 0 = active-low
- V_SYNC_POL, 0, 1 = v_sync active-high, 0 = active-low
- PIPE_DELAY, 2, extra clocks applied to h_sync/v_sync/video_on only (0..15)
- Derived (localparam): H_TOTAL = sum of the four H terms; V_TOTAL likewise; HW = $clog2(H_TOTAL); VW = $clog2(V_TOTAL).

Ports:
- clk_pixel  input  1  pixel clock
- reset_n  input  1  asynchronous, active-low reset
- enable  input  1  run counters; low = idle at origin
- x  output  HW  current horizontal count (registered)
- y  output  VW  current vertical count (registered)
- pixel_active  output  1  x < H_ACTIVE and y < V_ACTIVE; undelayed, aligned with x/y
- line_start  output  1  one-clock pulse when x==0
- frame_start  output  1  one-clock pulse when x==0 and y==0
- h_sync  output  1  horizontal sync at configured polarity, delayed by PIPE_DELAY
- v_sync  output  1  vertical sync at configured polarity, delayed by PIPE_DELAY
- video_on  output  1  pixel_active delayed by PIPE_DELAY
- v_blank  output  1  y >= V_ACTIVE; undelayed

Behaviour:
- Counters: hc in 0..H_TOTAL-1, vc in 0..V_TOTAL-1.
  - hc increments every clock while enable=1.
  - At H_TOTAL-1, hc wraps to 0 and vc increments.
  - When hc wraps with vc at V_TOTAL-1, vc also wraps to 0.
- enable=0: hc and vc are forced to 0 synchronously on the next clock and held there.
  - Strobes are suppressed while enable=0.
  - On the first clock after enable rises, the registered outputs present x=0, y=0 with frame_start=1.
- Registered outputs (1-clock latency from counters):
  - x=hc, y=vc, pixel_active, v_blank.
  - line_start = (hc==0) and enable.
  - frame_start = (hc==0 and vc==0) and enable.
- Raw sync:
  - hs_raw is asserted for H_ACTIVE+H_FRONT <= hc < H_ACTIVE+H_FRONT+H_SYNC.
  - vs_raw is asserted for the analogous vc range.
  - Each is driven at its polarity: output = asserted XNOR SYNC_POL, i.e. the inactive level is ~SYNC_POL.
- Delay line: {h_sync, v_sync, video_on} pass through a PIPE_DELAY-stage shift register after the output register.
  - PIPE_DELAY=0 means these are aligned with x/y.
  - Total latency from counter to delayed outputs = 1+PIPE_DELAY.
- Reset (reset_n low, asynchronous): counters 0, x=0, y=0.
  - pixel_active, line_start, frame_start, v_blank, video_on all 0.
  - h_sync = ~H_SYNC_POL and v_sync = ~V_SYNC_POL, at the output and in every delay stage.
  - Release is synchronous to clk_pixel.
- Reset or enable drop mid-frame: no partial-frame resume; the next frame starts at the origin.
- No combinational path from any input to any output.

Test Plan:
- Reset held low 10 clocks, enable=1:
  - h_sync=1, v_sync=1, video_on=0, x=0, y=0.
  - After release, the first frame_start pulse is followed by frame_start again exactly 420000 clocks later.
- Defaults, PIPE_DELAY=0:
  - h_sync low exactly while x is in 656..751 (96 clocks) on every line.
  - v_sync low only while y is 490..491.
- Defaults:
  - pixel_active high for 640 consecutive clocks per line on lines 0..479 and never on lines 480..524.
  - line_start count per frame = 525.
- PIPE_DELAY=3:
  - The video_on rising edge occurs 3 clocks after the pixel_active rising edge.
  - The h_sync falling edge occurs 3 clocks after x=656 is presented.
- H_SYNC_POL=1, V_SYNC_POL=1:
  - Reset values are h_sync=0 and v_sync=0.
  - h_sync high for 96 clocks per line.
- enable dropped at x=300, y=200 for 5 clocks, then raised:
  - x=y=0 during the hold.
  - Exactly one frame_start on the first enabled output clock.
  - No line_start during the hold.

Source files
------------

// File: rtl/vga_timing_core.sv
// vga_timing_core
//   Parametrised raster timing generator. Two free-running counters (hc, vc)
//   walk the full line/frame including blanking; every output is registered.
//   Sync and video_on additionally pass through a PIPE_DELAY-stage delay line
//   so they stay aligned with a downstream pixel pipeline of known latency.
//
// Ports
//   clk_pixel    in   pixel clock
//   reset_n      in   asynchronous active-low reset, released synchronously
//   enable       in   run counters; low parks the raster at the origin
//   x, y         out  registered horizontal / vertical count
//   pixel_active out  inside visible area, aligned with x/y
//   line_start   out  one-clock pulse at x==0
//   frame_start  out  one-clock pulse at x==0, y==0
//   h_sync       out  horizontal sync at H_SYNC_POL, delayed by PIPE_DELAY
//   v_sync       out  vertical sync at V_SYNC_POL, delayed by PIPE_DELAY
//   video_on     out  pixel_active delayed by PIPE_DELAY
//   v_blank      out  inside vertical blanking, aligned with x/y
module vga_timing_core #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0,
  parameter int unsigned PIPE_DELAY = 2,
  localparam int unsigned H_TOTAL   = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
  localparam int unsigned V_TOTAL   = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
  localparam int unsigned HW        = $clog2(H_TOTAL),
  localparam int unsigned VW        = $clog2(V_TOTAL)
) (
  input  logic          clk_pixel,
  input  logic          reset_n,
  input  logic          enable,
  output logic [HW-1:0] x,
  output logic [VW-1:0] y,
  output logic          pixel_active,
  output logic          line_start,
  output logic          frame_start,
  output logic          h_sync,
  output logic          v_sync,
  output logic          video_on,
  output logic          v_blank
);

  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FRONT;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FRONT;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ZERO = {HW{1'b0}};
  localparam logic [VW-1:0] V_ZERO = {VW{1'b0}};

  // Idle level of the {h_sync, v_sync, video_on} bundle.
  localparam logic [2:0] DLY_RST = {~H_SYNC_POL, ~V_SYNC_POL, 1'b0};

  logic [HW-1:0] hc_q, hc_d;
  logic [VW-1:0] vc_q, vc_d;

  logic [31:0] hc_ext_d, vc_ext_d;
  logic        h_act_d, v_act_d;
  logic        hs_raw_d, vs_raw_d;
  logic        pixel_active_d, v_blank_d;
  logic        line_start_d, frame_start_d;
  logic        h_sync_d, v_sync_d;

  logic [HW-1:0] x_q;
  logic [VW-1:0] y_q;
  logic          pixel_active_q, v_blank_q, line_start_q, frame_start_q;
  logic          h_sync_q, v_sync_q, video_on_q;

  // Counter next-state: dropping enable parks both counters at the origin so
  // the next run always begins with a fresh frame.
  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    if (!enable) begin
      hc_d = H_ZERO;
      vc_d = V_ZERO;
    end else if (hc_q == H_LAST) begin
      hc_d = H_ZERO;
      if (vc_q == V_LAST) begin
        vc_d = V_ZERO;
      end else begin
        vc_d = vc_q + VW'(1);
      end
    end else begin
      hc_d = hc_q + HW'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      hc_q <= H_ZERO;
      vc_q <= V_ZERO;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end

  // Region decode from the current counts. Compares are done at 32 bits so a
  // region bound equal to the total never wraps in the counter width.
  always_comb begin
    hc_ext_d       = 32'(hc_q);
    vc_ext_d       = 32'(vc_q);
    h_act_d        = (hc_ext_d < H_ACTIVE);
    v_act_d        = (vc_ext_d < V_ACTIVE);
    hs_raw_d       = (hc_ext_d >= H_SYNC_START) && (hc_ext_d < H_SYNC_END);
    vs_raw_d       = (vc_ext_d >= V_SYNC_START) && (vc_ext_d < V_SYNC_END);
    pixel_active_d = h_act_d && v_act_d;
    v_blank_d      = !v_act_d;
    // Strobes are gated by enable so nothing pulses while parked.
    line_start_d   = enable && (hc_q == H_ZERO);
    frame_start_d  = enable && (hc_q == H_ZERO) && (vc_q == V_ZERO);
    // asserted XNOR polarity: active level equals the polarity bit.
    h_sync_d       = ~(hs_raw_d ^ H_SYNC_POL);
    v_sync_d       = ~(vs_raw_d ^ V_SYNC_POL);
  end

  // Output register stage, one clock behind the counters.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      x_q            <= H_ZERO;
      y_q            <= V_ZERO;
      pixel_active_q <= 1'b0;
      v_blank_q      <= 1'b0;
      line_start_q   <= 1'b0;
      frame_start_q  <= 1'b0;
      h_sync_q       <= ~H_SYNC_POL;
      v_sync_q       <= ~V_SYNC_POL;
      video_on_q     <= 1'b0;
    end else begin
      x_q            <= hc_q;
      y_q            <= vc_q;
      pixel_active_q <= pixel_active_d;
      v_blank_q      <= v_blank_d;
      line_start_q   <= line_start_d;
      frame_start_q  <= frame_start_d;
      h_sync_q       <= h_sync_d;
      v_sync_q       <= v_sync_d;
      video_on_q     <= pixel_active_d;
    end
  end

  assign x            = x_q;
  assign y            = y_q;
  assign pixel_active = pixel_active_q;
  assign v_blank      = v_blank_q;
  assign line_start   = line_start_q;
  assign frame_start  = frame_start_q;

  generate
    if (PIPE_DELAY == 0) begin : g_no_dly
      assign h_sync   = h_sync_q;
      assign v_sync   = v_sync_q;
      assign video_on = video_on_q;
    end else begin : g_dly
      logic [2:0] dly_q [PIPE_DELAY];

      // Shift {h_sync, v_sync, video_on} through PIPE_DELAY stages; every
      // stage resets to the idle sync level so no false pulse escapes.
      always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < int'(PIPE_DELAY); i++) begin
            dly_q[i] <= DLY_RST;
          end
        end else begin
          dly_q[0] <= {h_sync_q, v_sync_q, video_on_q};
          for (int i = 1; i < int'(PIPE_DELAY); i++) begin
            dly_q[i] <= dly_q[i-1];
          end
        end
      end

      assign {h_sync, v_sync, video_on} = dly_q[PIPE_DELAY-1];
    end
  endgenerate

endmodule

// File: tb/tb_vga_timing_core.sv
// Directed bench for vga_timing_core. Four instances share one clock/reset:
//   u_def : default 640x480 timing, PIPE_DELAY=0 (line-level sync/active)
//   u_d3  : default timing, PIPE_DELAY=3 (delay-line alignment)
//   u_pol : default timing, active-high syncs, PIPE_DELAY=2
//   u_sm  : reduced 25x15 raster (frame-level behaviour, enable drop)
// The reduced raster keeps full-frame checks within a short run; its frame
// period is 25*15 = 375 clocks, the analogue of 800*525 = 420000.
module tb_vga_timing_core;

  logic clk_pixel = 1'b0;
  logic reset_n   = 1'b0;
  logic en_all    = 1'b1;
  logic en_sm     = 1'b1;

  always #5 clk_pixel = ~clk_pixel;

  logic [9:0] def_x, def_y, d3_x, d3_y, pol_x, pol_y;
  logic       def_pa, def_ls, def_fs, def_hs, def_vs, def_vo, def_vb;
  logic       d3_pa, d3_ls, d3_fs, d3_hs, d3_vs, d3_vo, d3_vb;
  logic       pol_pa, pol_ls, pol_fs, pol_hs, pol_vs, pol_vo, pol_vb;
  logic [4:0] sm_x;
  logic [3:0] sm_y;
  logic       sm_pa, sm_ls, sm_fs, sm_hs, sm_vs, sm_vo, sm_vb;

  vga_timing_core #(.PIPE_DELAY(0)) u_def (
    .clk_pixel(clk_pixel), .reset_n(reset_n), .enable(en_all),
    .x(def_x), .y(def_y), .pixel_active(def_pa), .line_start(def_ls),
    .frame_start(def_fs), .h_sync(def_hs), .v_sync(def_vs),
    .video_on(def_vo), .v_blank(def_vb));

  vga_timing_core #(.PIPE_DELAY(3)) u_d3 (
    .clk_pixel(clk_pixel), .reset_n(reset_n), .enable(en_all),
    .x(d3_x), .y(d3_y), .pixel_active(d3_pa), .line_start(d3_ls),
    .frame_start(d3_fs), .h_sync(d3_hs), .v_sync(d3_vs),
    .video_on(d3_vo), .v_blank(d3_vb));

  vga_timing_core #(.H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)) u_pol (
    .clk_pixel(clk_pixel), .reset_n(reset_n), .enable(en_all),
    .x(pol_x), .y(pol_y), .pixel_active(pol_pa), .line_start(pol_ls),
    .frame_start(pol_fs), .h_sync(pol_hs), .v_sync(pol_vs),
    .video_on(pol_vo), .v_blank(pol_vb));

  vga_timing_core #(
    .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_ACTIVE(8),  .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .PIPE_DELAY(0)
  ) u_sm (
    .clk_pixel(clk_pixel), .reset_n(reset_n), .enable(en_sm),
    .x(sm_x), .y(sm_y), .pixel_active(sm_pa), .line_start(sm_ls),
    .frame_start(sm_fs), .h_sync(sm_hs), .v_sync(sm_vs),
    .video_on(sm_vo), .v_blank(sm_vb));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Accumulators
  int def_hs_bad = 0, def_hs_low = 0, def_pa_bad = 0, def_pa_cnt = 0;
  int def_vs_low = 0, def_ls_cnt = 0;
  int d3_pa_rise = 0, d3_vo_rise = 0, d3_x656 = 0, d3_hs_fall = 0;
  logic d3_pa_prev, d3_vo_prev, d3_hs_prev;
  int pol_hs_hi = 0, pol_vs_hi = 0;
  int sm_vs_bad = 0, sm_vs_low = 0, sm_pa_bad = 0, sm_pa_cnt = 0;
  int sm_pa_blank = 0, sm_vb_bad = 0, sm_ls_cnt = 0;
  int sm_hold_bad = 0, sm_hold_strobe = 0;
  int sm_nfs = 0;
  int sm_fs_idx [4];

  initial begin
    for (int i = 0; i < 4; i++) sm_fs_idx[i] = 0;

    // Reset held for 10 clocks with enable high.
    repeat (10) @(negedge clk_pixel);
    check_eq("rst_def_hs", 32'(def_hs), 32'd1);
    check_eq("rst_def_vs", 32'(def_vs), 32'd1);
    check_eq("rst_def_vo", 32'(def_vo), 32'd0);
    check_eq("rst_def_x",  32'(def_x),  32'd0);
    check_eq("rst_def_y",  32'(def_y),  32'd0);
    check_eq("rst_def_pa", 32'(def_pa), 32'd0);
    check_eq("rst_def_ls", 32'(def_ls), 32'd0);
    check_eq("rst_def_fs", 32'(def_fs), 32'd0);
    check_eq("rst_def_vb", 32'(def_vb), 32'd0);
    check_eq("rst_d3_hs",  32'(d3_hs),  32'd1);
    check_eq("rst_d3_vs",  32'(d3_vs),  32'd1);
    check_eq("rst_pol_hs", 32'(pol_hs), 32'd0);
    check_eq("rst_pol_vs", 32'(pol_vs), 32'd0);
    check_eq("rst_sm_fs",  32'(sm_fs),  32'd0);

    d3_pa_prev = d3_pa;
    d3_vo_prev = d3_vo;
    d3_hs_prev = d3_hs;
    reset_n = 1'b1;

    // Sample s is taken on the falling edge after the s-th rising edge
    // following release; the default instances then show x = s-1 on line 0.
    for (int s = 1; s <= 2400; s++) begin
      @(negedge clk_pixel);

      // Default timing, no delay: three full lines 0..2.
      if ((def_hs == 1'b0) != (def_x >= 10'd656 && def_x <= 10'd751)) def_hs_bad++;
      if (!def_hs) def_hs_low++;
      if (def_pa != (def_x < 10'd640 && def_y < 10'd480)) def_pa_bad++;
      if (def_pa) def_pa_cnt++;
      if (!def_vs) def_vs_low++;
      if (def_ls) def_ls_cnt++;

      // Delay-line alignment.
      if (d3_pa && !d3_pa_prev && d3_pa_rise == 0) d3_pa_rise = s;
      if (d3_vo && !d3_vo_prev && d3_vo_rise == 0) d3_vo_rise = s;
      if (d3_x == 10'd656 && d3_x656 == 0) d3_x656 = s;
      if (!d3_hs && d3_hs_prev && d3_hs_fall == 0) d3_hs_fall = s;
      d3_pa_prev = d3_pa;
      d3_vo_prev = d3_vo;
      d3_hs_prev = d3_hs;

      // Active-high syncs.
      if (pol_hs) pol_hs_hi++;
      if (pol_vs) pol_vs_hi++;

      // Reduced raster, first full frame.
      if (s <= 375) begin
        if ((sm_vs == 1'b0) != (sm_y >= 4'd10 && sm_y <= 4'd11)) sm_vs_bad++;
        if (!sm_vs) sm_vs_low++;
        if (sm_pa != (sm_x < 5'd16 && sm_y < 4'd8)) sm_pa_bad++;
        if (sm_pa) sm_pa_cnt++;
        if (sm_pa && sm_y >= 4'd8) sm_pa_blank++;
        if (sm_vb != (sm_y >= 4'd8)) sm_vb_bad++;
        if (sm_ls) sm_ls_cnt++;
      end
      if (sm_fs) begin
        if (sm_nfs < 4) sm_fs_idx[sm_nfs] = s;
        sm_nfs++;
      end

      // Enable drop at x=10, y=5 of the second frame, held for 5 clocks.
      if (s >= 513 && s <= 516 && (sm_x != 5'd0 || sm_y != 4'd0)) sm_hold_bad++;
      if (s >= 512 && s <= 516 && (sm_ls || sm_fs)) sm_hold_strobe++;
      if (s == 511) begin
        check_eq("sm_drop_x", 32'(sm_x), 32'd10);
        check_eq("sm_drop_y", 32'(sm_y), 32'd5);
        en_sm = 1'b0;
      end
      if (s == 516) en_sm = 1'b1;
      if (s == 517) begin
        check_eq("sm_resume_x",  32'(sm_x),  32'd0);
        check_eq("sm_resume_y",  32'(sm_y),  32'd0);
        check_eq("sm_resume_fs", 32'(sm_fs), 32'd1);
      end
      if (s == 518) check_eq("sm_resume_x1", 32'(sm_x), 32'd1);
    end

    check_eq("def_hs_window_bad", 32'(def_hs_bad), 32'd0);
    check_eq("def_hs_low_cnt",    32'(def_hs_low), 32'd288);
    check_eq("def_pa_bad",        32'(def_pa_bad), 32'd0);
    check_eq("def_pa_cnt",        32'(def_pa_cnt), 32'd1920);
    check_eq("def_vs_low",        32'(def_vs_low), 32'd0);
    check_eq("def_ls_cnt",        32'(def_ls_cnt), 32'd3);
    check_eq("def_end_x",         32'(def_x),      32'd799);
    check_eq("def_end_y",         32'(def_y),      32'd2);

    check_eq("d3_pa_rise",   32'(d3_pa_rise), 32'd1);
    check_eq("d3_vo_rise",   32'(d3_vo_rise), 32'd4);
    check_eq("d3_vo_lag",    32'(d3_vo_rise - d3_pa_rise), 32'd3);
    check_eq("d3_x656_at",   32'(d3_x656),    32'd657);
    check_eq("d3_hs_lag",    32'(d3_hs_fall - d3_x656),    32'd3);

    check_eq("pol_hs_hi",    32'(pol_hs_hi), 32'd288);
    check_eq("pol_vs_hi",    32'(pol_vs_hi), 32'd0);

    check_eq("sm_vs_bad",    32'(sm_vs_bad),   32'd0);
    check_eq("sm_vs_low",    32'(sm_vs_low),   32'd50);
    check_eq("sm_pa_bad",    32'(sm_pa_bad),   32'd0);
    check_eq("sm_pa_cnt",    32'(sm_pa_cnt),   32'd128);
    check_eq("sm_pa_blank",  32'(sm_pa_blank), 32'd0);
    check_eq("sm_vb_bad",    32'(sm_vb_bad),   32'd0);
    check_eq("sm_ls_frame",  32'(sm_ls_cnt),   32'd15);
    check_eq("sm_fs0",       32'(sm_fs_idx[0]), 32'd1);
    check_eq("sm_fs1",       32'(sm_fs_idx[1]), 32'd376);
    check_eq("sm_fs2",       32'(sm_fs_idx[2]), 32'd517);
    check_eq("sm_fs3",       32'(sm_fs_idx[3]), 32'd892);
    check_eq("sm_fs_total",  32'(sm_nfs),       32'd8);
    check_eq("sm_hold_xy",   32'(sm_hold_bad),  32'd0);
    check_eq("sm_hold_strb", 32'(sm_hold_strobe), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
